// File: rtl/alu_muldiv_seq_pkg.sv
// Op codes, FSM encodings and op-class decode helpers shared by the ALU/muldiv block.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_muldiv_seq_pkg;

    typedef logic [4:0] op_t;

    // RV32I ALU ops
    localparam op_t OP_ADD    = 5'd0;
    localparam op_t OP_SUB    = 5'd1;
    localparam op_t OP_SLL    = 5'd2;
    localparam op_t OP_SLT    = 5'd3;
    localparam op_t OP_SLTU   = 5'd4;
    localparam op_t OP_XOR    = 5'd5;
    localparam op_t OP_SRL    = 5'd6;
    localparam op_t OP_SRA    = 5'd7;
    localparam op_t OP_OR     = 5'd8;
    localparam op_t OP_AND    = 5'd9;
    // branch compares
    localparam op_t OP_BEQ    = 5'd10;
    localparam op_t OP_BNE    = 5'd11;
    localparam op_t OP_BLT    = 5'd12;
    localparam op_t OP_BGE    = 5'd13;
    localparam op_t OP_BLTU   = 5'd14;
    localparam op_t OP_BGEU   = 5'd15;
    // RV32M: 16..19 multiply group, 20..23 divide group
    localparam op_t OP_MUL    = 5'd16;
    localparam op_t OP_MULH   = 5'd17;
    localparam op_t OP_MULHSU = 5'd18;
    localparam op_t OP_MULHU  = 5'd19;
    localparam op_t OP_DIV    = 5'd20;
    localparam op_t OP_DIVU   = 5'd21;
    localparam op_t OP_REM    = 5'd22;
    localparam op_t OP_REMU   = 5'd23;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    function automatic logic is_mul(input op_t op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic is_div(input op_t op);
        return op[4:2] == 3'b101;
    endfunction

    function automatic logic is_signed_a(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic want_high(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic want_rem(input op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_iter.sv
// Iterative core: shift-add multiply / restoring divide on magnitudes, sign fixed on the last step.
// Latency: start at edge N -> done high in cycle N+WIDTH, result valid alongside done (combinational).
// Backpressure: none; the caller must capture result in the done cycle. kill aborts at the next edge.
// Ports: start/op/a/b load a new operation; kill aborts; done/result report completion.
module alu_muldiv_seq_iter
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             kill,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               active_q, mul_q, high_q, rem_q, neg_q, neg_rem_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q, mcand_q;
    logic [WIDTH-1:0]   shreg_q, dvsr_q, rem_acc_q;

    logic               a_neg, b_neg, q_bit;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_nxt, quo_nxt, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_nxt, prod_fix;
    logic [WIDTH:0]     r_sh, diff;

    assign a_neg = is_signed_a(op) && a[WIDTH-1];
    assign b_neg = is_signed_b(op) && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // multiply: shreg holds the multiplier, consumed LSB first
    assign prod_nxt = prod_q + (shreg_q[0] ? mcand_q : '0);
    assign prod_fix = neg_q ? -prod_nxt : prod_nxt;

    // divide: shreg holds the dividend, quotient bits shift in from the right
    assign r_sh    = {rem_acc_q, shreg_q[WIDTH-1]};
    assign diff    = r_sh - {1'b0, dvsr_q};
    assign q_bit   = !diff[WIDTH];
    assign rem_nxt = q_bit ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign quo_nxt = {shreg_q[WIDTH-2:0], q_bit};
    assign quo_fix = neg_q ? -quo_nxt : quo_nxt;
    assign rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;

    assign done   = active_q && (cnt_q == LAST);
    assign result = mul_q ? (high_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0])
                          : (rem_q ? rem_fix : quo_fix);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q  <= 1'b0;
            mul_q     <= 1'b0;
            high_q    <= 1'b0;
            rem_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            shreg_q   <= '0;
            dvsr_q    <= '0;
            rem_acc_q <= '0;
        end else if (kill) begin
            active_q <= 1'b0;
        end else if (start) begin
            active_q  <= 1'b1;
            cnt_q     <= '0;
            mul_q     <= is_mul(op);
            high_q    <= want_high(op);
            rem_q     <= want_rem(op);
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            prod_q    <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, a_mag};
            shreg_q   <= is_mul(op) ? b_mag : a_mag;
            dvsr_q    <= b_mag;
            rem_acc_q <= '0;
        end else if (active_q) begin
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                active_q <= 1'b0;
            end
            if (mul_q) begin
                prod_q  <= prod_nxt;
                mcand_q <= mcand_q << 1;
                shreg_q <= shreg_q >> 1;
            end else begin
                rem_acc_q <= rem_nxt;
                shreg_q   <= quo_nxt;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU + branch compare (1 cycle, or 0 with REG_OUT=0) and iterative RV32M mul/div (WIDTH+1 cycles).
// Latency: ALU/branch/div-special N+REG_OUT; MUL*/DIV*/REM* accept at N -> out_valid at N+WIDTH+1.
// Backpressure: in_ready low while iterating, in HOLD, or while an untaken result sits on the output.
// Ports: clk/reset_n/flush control; in_valid/in_ready/op/a/b request; out_valid/out_ready/result/branch_enable
//        response; busy flags an iterative op in flight.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             branch_enable,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q;
    logic             out_valid_q, br_q;
    logic [WIDTH-1:0] result_q;

    logic             accept, div_special, iter_op, single_acc, start, bypass;
    logic             eq, ltu, lt, br_res, core_done;
    logic [WIDTH:0]   cmp_diff;
    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] alu_res, core_result;

    // Without an output register a held result blocks new work outright.
    assign in_ready = reset_n && (state_q == ST_IDLE)
                   && !(out_valid_q && (!out_ready || !REG_OUT));
    assign accept   = in_valid && in_ready;

    // Divide by zero and signed overflow resolve in one cycle without iterating.
    assign div_special = is_div(op) && ((b == '0) || (is_signed_a(op) && (a == MIN_NEG) && (b == '1)));
    assign iter_op     = is_mul(op) || (is_div(op) && !div_special);
    assign single_acc  = accept && !iter_op && !flush;
    assign start       = accept && iter_op && !flush;
    assign bypass      = !REG_OUT && single_acc;

    assign sh       = b[SW-1:0];
    assign cmp_diff = {1'b0, a} - {1'b0, b};
    assign eq       = (cmp_diff == '0);
    assign ltu      = cmp_diff[WIDTH];
    // same signs: signed order equals unsigned order
    assign lt       = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : ltu;

    always_comb begin
        alu_res = '0;
        br_res  = 1'b0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << sh;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltu};
            OP_XOR:  alu_res = a ^ b;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> sh);
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_BEQ:  br_res  = eq;
            OP_BNE:  br_res  = !eq;
            OP_BLT:  br_res  = lt;
            OP_BGE:  br_res  = !lt;
            OP_BLTU: br_res  = ltu;
            OP_BGEU: br_res  = !ltu;
            // only reached for the single-cycle special cases; overflow quotient equals a
            OP_DIV, OP_DIVU: alu_res = (b == '0) ? '1 : a;
            OP_REM, OP_REMU: alu_res = (b == '0) ? a : '0;
            default: alu_res = '0;
        endcase
    end

    alu_muldiv_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .kill    (flush),
        .op      (op),
        .a       (a),
        .b       (b),
        .done    (core_done),
        .result  (core_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_q        <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (single_acc) begin
                        // in bypass mode only keep the result if the consumer did not take it
                        out_valid_q <= REG_OUT ? 1'b1 : !out_ready;
                        result_q    <= alu_res;
                        br_q        <= br_res;
                    end else if (start) begin
                        state_q     <= is_mul(op) ? ST_MUL : ST_DIV;
                        out_valid_q <= 1'b0;
                    end else if (out_valid_q) begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (core_done) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b1;
                        result_q    <= core_result;
                        br_q        <= 1'b0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid     = out_valid_q || bypass;
    assign result        = bypass ? alu_res : result_q;
    assign branch_enable = bypass ? br_res : br_q;
    assign busy          = (state_q == ST_MUL) || (state_q == ST_DIV);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n, flush, in_valid, in_ready, out_valid, out_ready, branch_enable, busy;
    op_t          op;
    logic [W-1:0] a, b, result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.WIDTH(W), .REG_OUT(1'b1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .branch_enable (branch_enable),
        .busy          (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for one accept edge; leaves the bench in cycle N+1.
    task automatic drive_op(input op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready op=%0d in_ready=%b want 1", o, in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = OP_ADD; a = '0; b = '0;
        #12;
        checks++;
        if ({out_valid, busy, branch_enable, in_ready} !== 4'b0000 || result !== '0) begin
            errors++;
            $display("FAIL reset_state vld/busy/br/rdy=%b%b%b%b result=%h want 0000/0",
                     out_valid, busy, branch_enable, in_ready, result);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_alu();
        op_t          t_op[$];
        logic [W-1:0] t_a[$], t_b[$], t_r[$];
        t_op = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, 5'd31};
        t_a  = '{32'h7FFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                 32'h8000_0000, 32'h8000_0000, 32'h0F0, 32'hF0, 32'h5};
        t_b  = '{32'h1, 32'h1, 32'd33, 32'h1, 32'h1, 32'hFF00_FF00, 32'h4, 32'h4, 32'h00F, 32'h3C, 32'h6};
        t_r  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'h0, 32'h0FF0_0FF0,
                 32'h0800_0000, 32'hF800_0000, 32'h0FF, 32'h30, 32'h0};
        foreach (t_op[i]) begin
            drive_op(t_op[i], t_a[i], t_b[i]);
            checks++;
            if (out_valid !== 1'b1 || result !== t_r[i] || branch_enable !== 1'b0) begin
                errors++;
                $display("FAIL alu_op%0d vld=%b result=%h br=%b want 1/%h/0",
                         t_op[i], out_valid, result, branch_enable, t_r[i]);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_drain out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_branch();
        op_t          t_op[$];
        logic [W-1:0] t_a[$], t_b[$];
        logic         t_e[$];
        t_op = '{OP_BLTU, OP_BLT, OP_BEQ, OP_BNE, OP_BGE, OP_BGEU};
        t_a  = '{32'h1, 32'h1, 32'h5, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_b  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h5, 32'h1, 32'h1};
        t_e  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        foreach (t_op[i]) begin
            drive_op(t_op[i], t_a[i], t_b[i]);
            checks++;
            if (out_valid !== 1'b1 || branch_enable !== t_e[i] || result !== '0) begin
                errors++;
                $display("FAIL branch_op%0d vld=%b br=%b result=%h want 1/%b/0",
                         t_op[i], out_valid, branch_enable, result, t_e[i]);
            end
        end
        step();
    endtask

    task automatic test_mulh_timing();
        drive_op(OP_MULH, 32'h8000_0000, 32'h8000_0000);
        for (int k = 1; k <= W; k++) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mulh_cycle%0d busy=%b in_ready=%b out_valid=%b want 1/0/0",
                         k, busy, in_ready, out_valid);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h4000_0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mulh_done vld=%b result=%h busy=%b want 1/40000000/0",
                     out_valid, result, busy);
        end
        step();
    endtask

    task automatic test_iterative();
        op_t          t_op[$];
        logic [W-1:0] t_a[$], t_b[$], t_r[$];
        int           cnt;
        t_op = '{OP_MUL, OP_MULHU, OP_MULHSU, OP_MULH, OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        t_a  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                 32'd100, 32'd100, 32'd100, 32'd100};
        t_b  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'd2, 32'd2,
                 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        t_r  = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFF2, 32'd2};
        foreach (t_op[i]) begin
            drive_op(t_op[i], t_a[i], t_b[i]);
            cnt = 1;
            while (out_valid !== 1'b1 && cnt < 40) begin
                step();
                cnt++;
            end
            checks++;
            if (out_valid !== 1'b1 || result !== t_r[i] || cnt != W + 1) begin
                errors++;
                $display("FAIL iter_op%0d vld=%b result=%h at N+%0d want %h at N+%0d",
                         t_op[i], out_valid, result, cnt, t_r[i], W + 1);
            end
        end
        step();
    endtask

    task automatic test_div_special();
        op_t          t_op[$];
        logic [W-1:0] t_a[$], t_b[$], t_r[$];
        t_op = '{OP_DIV, OP_DIVU, OP_REM, OP_REM, OP_DIV};
        t_a  = '{32'h8000_0000, 32'd7, 32'd5, 32'h8000_0000, 32'd5};
        t_b  = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        t_r  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFF};
        foreach (t_op[i]) begin
            drive_op(t_op[i], t_a[i], t_b[i]);
            checks++;
            if (out_valid !== 1'b1 || result !== t_r[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL divspecial_op%0d vld=%b result=%h busy=%b want 1/%h/0",
                         t_op[i], out_valid, result, busy, t_r[i]);
            end
        end
        step();
    endtask

    task automatic test_hold();
        int cnt;
        int xfers;
        out_ready = 1'b0;
        drive_op(OP_MUL, 32'd3, 32'd5);
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd15 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d vld=%b result=%h in_ready=%b want 1/0000000f/0",
                         k, out_valid, result, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        xfers = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid === 1'b1) xfers++;
            step();
        end
        checks++;
        if (xfers != 1) begin
            errors++;
            $display("FAIL hold_release transfers=%0d want 1", xfers);
        end
    endtask

    task automatic test_flush();
        int seen;
        drive_op(OP_DIV, 32'd100, 32'd7);
        for (int k = 1; k < 10; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_div busy=%b vld=%b in_ready=%b want 0/0/1", busy, out_valid, in_ready);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_div_quiet out_valid cycles=%0d want 0", seen);
        end
        drive_op(OP_ADD, 32'd2, 32'd3);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5) begin
            errors++;
            $display("FAIL flush_then_add vld=%b result=%h want 1/00000005", out_valid, result);
        end
        step();
        // flush beats a same-cycle accept
        op = OP_ADD; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_accept vld=%b busy=%b want 0/0", out_valid, busy);
        end
        // flush beats a same-cycle completion (cycle N+WIDTH)
        drive_op(OP_MUL, 32'd6, 32'd7);
        for (int k = 1; k < W; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_complete vld=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        drive_op(OP_MUL, 32'd3, 32'd5);
        for (int k = 0; k < 5; k++) step();
        reset_n = 1'b0;
        #2;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b000 || result !== '0) begin
            errors++;
            $display("FAIL reset_midop vld/busy/rdy=%b%b%b result=%h want 000/0",
                     out_valid, busy, in_ready, result);
        end
        step();
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_midop_quiet out_valid cycles=%0d want 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mulh_timing();
        test_iterative();
        test_div_special();
        test_hold();
        test_flush();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
